seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder: it watches a time-multiplexed, active-low 7-segment display bus and recovers the hex nibble shown on each digit.
- Used by the calculator self-check path and testbench monitors to read back what the display drivers are showing.
- Filters anode and segment transitions through a stability counter and stores one nibble plus a valid bit per digit.

Parameters:
- DIGITS, 4, number of multiplexed digits (anode lines); legal range 1..8.
- STABLE_CYCLES, 4, number of consecutive identical samples required before a capture; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- seg_n  input  7  segment lines {a,b,c,d,e,f,g}, with a as the MSB; active-low (0 = lit).
- an_n  input  DIGITS  anode selects; active-low, one-hot when valid; bit i selects digit i.
- hex_out  output  4*DIGITS  recovered nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  output  DIGITS  1 = the stored nibble for digit i comes from a legal glyph.
- upd  output  1  one-cycle pulse when any digit slot is written, including a blank or error write.
- upd_idx  output  3  index of the slot written; meaningful only while upd = 1.
- pat_err  output  1  one-cycle pulse when a stable, non-glyph, non-blank pattern is captured.
- sel_err  output  1  one-cycle pulse when a stable an_n has zero or more than one bit low.

Behaviour:
- Input stage:
  - seg_n and an_n are registered once every cycle (samples S_k).
  - Comparison and counting always use registered samples, never the raw pins.
- FSM states are SETTLE, CAPTURED, and SELERR.
  - Counter cnt is 8 bits wide.
  - Whenever S_k differs from S_k-1, the next state is SETTLE and cnt is set to 1, from any state.
  - In SETTLE with S_k equal to S_k-1, cnt increments.
  - When cnt reaches STABLE_CYCLES and an_n is one-hot, the block captures and moves to CAPTURED.
  - When cnt reaches STABLE_CYCLES and an_n is not one-hot, sel_err pulses and the block moves to SELERR.
  - CAPTURED and SELERR hold until the input changes. There is exactly one capture or error per stable interval.
- Latency:
  - If the pins are constant across sampling edges E1..EN (N = STABLE_CYCLES), the outputs update at edge EN+1.
  - upd, upd_idx and pat_err are high for the one cycle that follows EN+1.
- Decode table (seg_n to nibble):
  - 0000001 → 0, 1001111 → 1, 0010010 → 2, 0000110 → 3
  - 1001100 → 4, 0100100 → 5, 0100000 → 6, 0001111 → 7
  - 0000000 → 8, 0001100 → 9, 0001000 → A, 1100000 → b
  - 0110001 → C, 1000010 → d, 0110000 → E, 0111000 → F
- Capture into slot i (the low bit of an_n):
  - Legal glyph: nibble written to hex_out[4i+3:4i], digit_valid[i] set to 1, upd = 1, upd_idx = i.
  - Blank (1111111): nibble retained, digit_valid[i] set to 0, upd = 1, no error.
  - Any other pattern: nibble retained, digit_valid[i] set to 0, upd = 1, pat_err = 1.
- Only slot i changes on a capture; all other slots hold their values.
- Reset (rst_n = 0 at a clock edge, including mid-settle or mid-capture):
  - hex_out = 0, digit_valid = 0, upd = 0, upd_idx = 0, pat_err = 0, sel_err = 0.
  - Sample registers are set to all-ones (blank, no anode), cnt = 0, state = SETTLE.
  - The first post-reset sample is treated as a change.
- cnt saturates and never wraps.
- With STABLE_CYCLES = 1, any sample that differs from its predecessor captures on the next edge.

Optional Feature:
- Macro name: SEGDEC_DP_EN.
- When defined:
  - Adds an input dp_n (1 bit, active-low decimal point).
  - Adds an output dp_out (DIGITS bits).
  - dp_n is registered and included in the stability comparison.
  - On any capture, dp_out[i] = ~dp_n, and dp_out resets to 0.
- When undefined:
  - Neither port exists.
  - The decimal point has no effect on stability or capture.

Test Plan:
- Reset, then an_n = 1110 and seg_n = 0010010 held for 5 cycles → hex_out[3:0] = 2, digit_valid = 0001, a single upd pulse with upd_idx = 0, exactly 5 edges after the first sample.
- Scan 4 digits with patterns 0000110, 0001000, 1000010, 0111000, 6 cycles each → hex_out = 16'hFDA3, digit_valid = 1111, four upd pulses.
- Hold an_n = 1101 while seg_n toggles every 2 cycles for 20 cycles → no upd, outputs unchanged; then hold for 4 cycles → exactly one capture.
- an_n = 0011 stable for 4 cycles → sel_err pulses once, no slot changes; an_n = 1111 stable → sel_err also pulses.
- After slot 2 holds 7, apply seg_n = 1010101 to slot 2 → pat_err pulses, digit_valid[2] = 0, hex_out[11:8] stays 7; blank 1111111 → no pat_err.
- Assert rst_n = 0 during SETTLE with cnt = 3 → all outputs 0 at the next edge; the same stable input after release needs the full STABLE_CYCLES+1 edges to capture.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Watches a time-multiplexed, active-low seven-segment display bus and
// recovers the hex nibble shown on each digit. Both the segment and anode
// buses pass through a stability filter before anything is captured. The
// filter makes exactly one capture, or one select error, for each stable
// interval.
//
// Parameters:
//   DIGITS        number of multiplexed digits / anode lines (1..8)
//   STABLE_CYCLES identical consecutive samples needed before capture (1..255)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   seg_n[6:0]   segments {a,b,c,d,e,f,g}, a = MSB, 0 = lit
//   an_n         anode selects, active-low, bit i = digit i
//   hex_out      recovered nibbles, digit i at [4i+3:4i]
//   digit_valid  1 = slot i holds a nibble decoded from a legal glyph
//   upd          one-cycle pulse on any slot write (glyph, blank or error)
//   upd_idx      slot written, meaningful while upd = 1
//   pat_err      one-cycle pulse on a stable non-glyph, non-blank pattern
//   sel_err      one-cycle pulse on a stable an_n that is not one-hot
//
// Optional feature, enabled by defining SEGDEC_DP_EN:
//   dp_n         active-low decimal point input, part of the stability check
//   dp_out       per-digit decimal point captured alongside each slot write

module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
`ifdef SEGDEC_DP_EN
    input  logic                  dp_n,
    output logic [DIGITS-1:0]     dp_out,
`endif
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  upd,
    output logic [2:0]            upd_idx,
    output logic                  pat_err,
    output logic                  sel_err
);

    typedef enum logic [1:0] {SETTLE, CAPTURED, SELERR} state_t;

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    state_t              state, state_d;
    logic [7:0]          cnt, cnt_d;
    logic [6:0]          seg_s, seg_p;
    logic [DIGITS-1:0]   an_s, an_p;
    logic                samp_vld, prev_vld;
    logic                changed;
    logic                do_cap, do_sel;
    logic                sel_one;
    logic [DIGITS-1:0]   an_inv;
    logic [2:0]          cap_idx;
    logic                glyph_ok;
    logic [3:0]          glyph_nib;
    logic                is_blank;
`ifdef SEGDEC_DP_EN
    logic                dp_s, dp_p;
`endif

    // Sample pipeline. seg_s/an_s hold the newest sample and seg_p/an_p hold
    // the one before it. The valid flags prevent the reset fill value from
    // being compared as if it were real data, so the first real sample
    // always counts as a change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s    <= '1;
            seg_p    <= '1;
            an_s     <= '1;
            an_p     <= '1;
            samp_vld <= 1'b0;
            prev_vld <= 1'b0;
            state    <= SETTLE;
            cnt      <= '0;
`ifdef SEGDEC_DP_EN
            dp_s     <= 1'b1;
            dp_p     <= 1'b1;
`endif
        end else begin
            seg_p    <= seg_s;
            seg_s    <= seg_n;
            an_p     <= an_s;
            an_s     <= an_n;
            samp_vld <= 1'b1;
            prev_vld <= samp_vld;
            state    <= state_d;
            cnt      <= cnt_d;
`ifdef SEGDEC_DP_EN
            dp_p     <= dp_s;
            dp_s     <= dp_n;
`endif
        end
    end

`ifdef SEGDEC_DP_EN
    assign changed = !prev_vld || (seg_s != seg_p) || (an_s != an_p) || (dp_s != dp_p);
`else
    assign changed = !prev_vld || (seg_s != seg_p) || (an_s != an_p);
`endif

    // An anode word is one-hot when exactly one bit is low. The capture slot
    // is the position of that low bit.
    assign an_inv  = ~an_s;
    assign sel_one = (an_inv != '0) && ((an_inv & (an_inv - 1'b1)) == '0);

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s[i]) cap_idx = 3'(i);
        end
    end

    // Glyph decoder.
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_nib = 4'h0;
        case (seg_s)
            7'b0000001: glyph_nib = 4'h0;
            7'b1001111: glyph_nib = 4'h1;
            7'b0010010: glyph_nib = 4'h2;
            7'b0000110: glyph_nib = 4'h3;
            7'b1001100: glyph_nib = 4'h4;
            7'b0100100: glyph_nib = 4'h5;
            7'b0100000: glyph_nib = 4'h6;
            7'b0001111: glyph_nib = 4'h7;
            7'b0000000: glyph_nib = 4'h8;
            7'b0001100: glyph_nib = 4'h9;
            7'b0001000: glyph_nib = 4'hA;
            7'b1100000: glyph_nib = 4'hB;
            7'b0110001: glyph_nib = 4'hC;
            7'b1000010: glyph_nib = 4'hD;
            7'b0110000: glyph_nib = 4'hE;
            7'b0111000: glyph_nib = 4'hF;
            default:    glyph_ok  = 1'b0;
        endcase
    end

    assign is_blank = (seg_s == 7'b1111111);

    // Next-state logic. A change restarts the count at 1 from any state.
    // The capture or select error fires on the edge where the count reaches
    // STABLE_CYCLES. Because of that, with STABLE_CYCLES = 1 the change
    // edge itself captures.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        do_cap  = 1'b0;
        do_sel  = 1'b0;
        if (samp_vld) begin
            if (changed) begin
                state_d = SETTLE;
                cnt_d   = 8'd1;
            end else if (state == SETTLE && cnt != 8'hFF) begin
                cnt_d = cnt + 8'd1;
            end
            if (state_d == SETTLE && cnt_d == STABLE_CNT) begin
                if (sel_one) begin
                    state_d = CAPTURED;
                    do_cap  = 1'b1;
                end else begin
                    state_d = SELERR;
                    do_sel  = 1'b1;
                end
            end
        end
    end

    // Slot storage and pulse outputs. Only the addressed slot is touched.
    // Blank and illegal patterns keep the old nibble and clear its valid bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex_out     <= '0;
            digit_valid <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
            pat_err     <= 1'b0;
            sel_err     <= 1'b0;
`ifdef SEGDEC_DP_EN
            dp_out      <= '0;
`endif
        end else begin
            upd     <= do_cap;
            pat_err <= do_cap && !glyph_ok && !is_blank;
            sel_err <= do_sel;
            if (do_cap) upd_idx <= cap_idx;
            for (int i = 0; i < DIGITS; i++) begin
                if (do_cap && (cap_idx == 3'(i))) begin
                    if (glyph_ok) begin
                        hex_out[4*i +: 4] <= glyph_nib;
                        digit_valid[i]    <= 1'b1;
                    end else begin
                        digit_valid[i]    <= 1'b0;
                    end
`ifdef SEGDEC_DP_EN
                    dp_out[i] <= ~dp_s;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic [15:0] hex_out;
    logic [3:0]  digit_valid;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        pat_err;
    logic        sel_err;
`ifdef SEGDEC_DP_EN
    logic        dp_n = 1'b1;
    logic [3:0]  dp_out;
`endif

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;
    int pat_cnt = 0;
    int sel_cnt = 0;

    seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_n(seg_n),
        .an_n(an_n),
`ifdef SEGDEC_DP_EN
        .dp_n(dp_n),
        .dp_out(dp_out),
`endif
        .hex_out(hex_out),
        .digit_valid(digit_valid),
        .upd(upd),
        .upd_idx(upd_idx),
        .pat_err(pat_err),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (upd === 1'b1) upd_cnt++;
        if (pat_err === 1'b1) pat_cnt++;
        if (sel_err === 1'b1) sel_cnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        upd_cnt = 0;
        pat_cnt = 0;
        sel_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++;
        if (hex_out !== 16'h0) begin failures++; $display("[TB] FAIL reset_hex: got %h expected 0000", hex_out); end
        checks++;
        if (digit_valid !== 4'h0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0000", digit_valid); end
        checks++;
        if ({upd, pat_err, sel_err} !== 3'b000) begin failures++; $display("[TB] FAIL reset_pulses: got %b expected 000", {upd, pat_err, sel_err}); end
        checks++;
        if (upd_idx !== 3'd0) begin failures++; $display("[TB] FAIL reset_upd_idx: got %0d expected 0", upd_idx); end
    endtask

    task automatic test_single_capture();
        clear_counts();
        rst_n = 1'b1;
        an_n  = 4'b1110;
        seg_n = 7'b0010010;
        tick(4);
        checks++;
        if (upd !== 1'b0 || hex_out !== 16'h0) begin failures++; $display("[TB] FAIL single_early: upd=%b hex=%h expected upd=0 hex=0000", upd, hex_out); end
        tick(1);
        checks++;
        if (upd !== 1'b1) begin failures++; $display("[TB] FAIL single_upd: got %b expected 1", upd); end
        checks++;
        if (upd_idx !== 3'd0) begin failures++; $display("[TB] FAIL single_idx: got %0d expected 0", upd_idx); end
        checks++;
        if (hex_out[3:0] !== 4'h2 || digit_valid !== 4'b0001) begin failures++; $display("[TB] FAIL single_data: hex=%h valid=%b expected nibble 2 valid 0001", hex_out, digit_valid); end
        tick(3);
        checks++;
        if (upd_cnt != 1) begin failures++; $display("[TB] FAIL single_pulse_count: got %0d expected 1", upd_cnt); end
    endtask

    task automatic test_scan();
        logic [3:0] an_tab  [4];
        logic [6:0] seg_tab [4];
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b0000110, 7'b0001000, 7'b1000010, 7'b0111000};
        clear_counts();
        for (int d = 0; d < 4; d++) begin
            an_n  = an_tab[d];
            seg_n = seg_tab[d];
            tick(6);
        end
        checks++;
        if (hex_out !== 16'hFDA3) begin failures++; $display("[TB] FAIL scan_hex: got %h expected fda3", hex_out); end
        checks++;
        if (digit_valid !== 4'b1111) begin failures++; $display("[TB] FAIL scan_valid: got %b expected 1111", digit_valid); end
        checks++;
        if (upd_cnt != 4) begin failures++; $display("[TB] FAIL scan_upd_count: got %0d expected 4", upd_cnt); end
    endtask

    task automatic test_glitch_filter();
        clear_counts();
        an_n = 4'b1101;
        for (int t = 0; t < 10; t++) begin
            seg_n = (t % 2 == 0) ? 7'b1001111 : 7'b0000000;
            tick(2);
        end
        checks++;
        if (upd_cnt != 0 || hex_out !== 16'hFDA3) begin failures++; $display("[TB] FAIL glitch_no_capture: upd_cnt=%0d hex=%h expected 0 fda3", upd_cnt, hex_out); end
        seg_n = 7'b0100100;
        tick(12);
        checks++;
        if (upd_cnt != 1) begin failures++; $display("[TB] FAIL glitch_one_capture: got %0d expected 1", upd_cnt); end
        checks++;
        if (hex_out !== 16'hFD53) begin failures++; $display("[TB] FAIL glitch_hex: got %h expected fd53", hex_out); end
    endtask

    task automatic test_sel_err();
        clear_counts();
        an_n  = 4'b0011;
        seg_n = 7'b0000110;
        tick(4);
        checks++;
        if (sel_err !== 1'b0) begin failures++; $display("[TB] FAIL sel_early: got %b expected 0", sel_err); end
        tick(1);
        checks++;
        if (sel_err !== 1'b1) begin failures++; $display("[TB] FAIL sel_pulse: got %b expected 1", sel_err); end
        tick(5);
        checks++;
        if (sel_cnt != 1 || upd_cnt != 0) begin failures++; $display("[TB] FAIL sel_counts: sel=%0d upd=%0d expected 1 0", sel_cnt, upd_cnt); end
        checks++;
        if (hex_out !== 16'hFD53 || digit_valid !== 4'b1111) begin failures++; $display("[TB] FAIL sel_hold: hex=%h valid=%b expected fd53 1111", hex_out, digit_valid); end
        clear_counts();
        an_n = 4'b1111;
        tick(8);
        checks++;
        if (sel_cnt != 1 || upd_cnt != 0) begin failures++; $display("[TB] FAIL sel_none_low: sel=%0d upd=%0d expected 1 0", sel_cnt, upd_cnt); end
    endtask

    task automatic test_pat_err();
        clear_counts();
        an_n  = 4'b1011;
        seg_n = 7'b0001111;
        tick(6);
        checks++;
        if (hex_out[11:8] !== 4'h7 || digit_valid[2] !== 1'b1) begin failures++; $display("[TB] FAIL pat_setup: nibble=%h valid=%b expected 7 1", hex_out[11:8], digit_valid[2]); end
        clear_counts();
        seg_n = 7'b1010101;
        tick(5);
        checks++;
        if (pat_err !== 1'b1 || upd !== 1'b1 || upd_idx !== 3'd2) begin failures++; $display("[TB] FAIL pat_pulse: pat=%b upd=%b idx=%0d expected 1 1 2", pat_err, upd, upd_idx); end
        checks++;
        if (digit_valid !== 4'b1011 || hex_out !== 16'hF753) begin failures++; $display("[TB] FAIL pat_slot: valid=%b hex=%h expected 1011 f753", digit_valid, hex_out); end
        tick(2);
        clear_counts();
        seg_n = 7'b1111111;
        tick(8);
        checks++;
        if (pat_cnt != 0 || upd_cnt != 1) begin failures++; $display("[TB] FAIL blank_counts: pat=%0d upd=%0d expected 0 1", pat_cnt, upd_cnt); end
        checks++;
        if (digit_valid !== 4'b1011 || hex_out[11:8] !== 4'h7) begin failures++; $display("[TB] FAIL blank_slot: valid=%b nibble=%h expected 1011 7", digit_valid, hex_out[11:8]); end
    endtask

    task automatic test_reset_mid_settle();
        clear_counts();
        an_n  = 4'b1110;
        seg_n = 7'b0100000;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        checks++;
        if (hex_out !== 16'h0 || digit_valid !== 4'h0 || {upd, pat_err, sel_err} !== 3'b000) begin failures++; $display("[TB] FAIL midreset_clear: hex=%h valid=%b pulses=%b expected 0000 0000 000", hex_out, digit_valid, {upd, pat_err, sel_err}); end
        rst_n = 1'b1;
        tick(4);
        checks++;
        if (upd !== 1'b0 || hex_out !== 16'h0) begin failures++; $display("[TB] FAIL midreset_early: upd=%b hex=%h expected 0 0000", upd, hex_out); end
        tick(1);
        checks++;
        if (upd !== 1'b1 || hex_out !== 16'h0006 || digit_valid !== 4'b0001) begin failures++; $display("[TB] FAIL midreset_capture: upd=%b hex=%h valid=%b expected 1 0006 0001", upd, hex_out, digit_valid); end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_single_capture();
        test_scan();
        test_glitch_filter();
        test_sel_err();
        test_pat_err();
        test_reset_mid_settle();
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
